// File: rtl/lfsr_byte_source.sv
// lfsr_byte_source
// Sequencing controller and output stage for an external 8-bit Fibonacci LFSR
// (x^8+x^7+x^6+x^4+1). It seeds the LFSR and advances it SHIFTS_PER_BYTE times
// per byte. Each resulting LFSR value goes into a small first-word-fall-through
// FIFO, which feeds a valid/ready byte stream.
//
// Every signal driven towards the LFSR is registered. lfsr_shift therefore
// follows the run input of the previous cycle while the FSM stays in GEN.

module lfsr_byte_source #(
    parameter int unsigned SHIFTS_PER_BYTE = 8,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [7:0]  ZERO_SEED_SUB   = 8'h01
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    seed,
    input  logic                          seed_load,
    input  logic                          run,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          seeded,
    output logic                          lfsr_rst,
    output logic [7:0]                    lfsr_init,
    output logic                          lfsr_shift,
    input  logic [7:0]                    lfsr_result
);

    // state   | meaning
    // --------+-----------------------------------------------------------
    // IDLE    | not seeded yet (or after reset); LFSR left alone
    // SEED    | lfsr_rst high for one cycle, LFSR loads lfsr_init
    // GEN     | LFSR advances on every cycle with run high; shifts counted
    // CAPTURE | LFSR frozen; its value is pushed once the FIFO has room

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [7:0]       LAST_SHIFT = 8'(SHIFTS_PER_BYTE - 1);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEED    = 2'd1,
        GEN     = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       shift_count;
    logic [7:0]       shift_count_next;
    logic             seeded_next;
    logic             lfsr_rst_next;
    logic [7:0]       lfsr_init_next;
    logic             lfsr_shift_next;

    logic             push;
    logic             pop;
    logic             flush;
    logic             fifo_full;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [7:0]       fifo_mem [FIFO_DEPTH];

    assign fifo_full = (level == FULL_LEVEL);
    assign out_valid = (level != '0);
    // Gated so that the data output reads zero while the FIFO is empty.
    // The storage itself is never reset.
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : 8'h00;

    // Control registers, including everything driven towards the LFSR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            shift_count <= 8'h00;
            seeded      <= 1'b0;
            lfsr_rst    <= 1'b0;
            lfsr_init   <= 8'h00;
            lfsr_shift  <= 1'b0;
        end else begin
            state       <= state_next;
            shift_count <= shift_count_next;
            seeded      <= seeded_next;
            lfsr_rst    <= lfsr_rst_next;
            lfsr_init   <= lfsr_init_next;
            lfsr_shift  <= lfsr_shift_next;
        end
    end

    // Next state, next values of the LFSR-side registers, and the FIFO strobes
    always_comb begin
        state_next       = state;
        shift_count_next = shift_count;
        seeded_next      = seeded;
        lfsr_rst_next    = 1'b0;
        lfsr_init_next   = lfsr_init;
        lfsr_shift_next  = 1'b0;
        push             = 1'b0;
        pop              = out_valid && out_ready;
        flush            = 1'b0;

        if (seed_load) begin
            // A reseed overrides everything else. The current byte is dropped.
            // The FIFO is emptied on this edge, so no byte from the old
            // sequence can be handed out after the reseed.
            state_next       = SEED;
            shift_count_next = 8'h00;
            seeded_next      = 1'b1;
            lfsr_rst_next    = 1'b1;
            lfsr_init_next   = (seed == 8'h00) ? ZERO_SEED_SUB : seed;
            pop              = 1'b0;
            flush            = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                SEED: begin
                    state_next       = GEN;
                    shift_count_next = 8'h00;
                    lfsr_shift_next  = run;
                end
                GEN: begin
                    if (lfsr_shift) begin
                        shift_count_next = shift_count + 8'd1;
                        if (shift_count == LAST_SHIFT) begin
                            // That was the last shift for this byte. The LFSR
                            // is frozen in CAPTURE until the byte is stored.
                            state_next = CAPTURE;
                        end else begin
                            lfsr_shift_next = run;
                        end
                    end else begin
                        lfsr_shift_next = run;
                    end
                end
                CAPTURE: begin
                    // A pop in the same cycle frees the slot being written.
                    if (!fifo_full || pop) begin
                        push             = 1'b1;
                        shift_count_next = 8'h00;
                        state_next       = GEN;
                        lfsr_shift_next  = run;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // FIFO storage; a captured LFSR value is written at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= lfsr_result;
        end
    end

endmodule
